// File: rtl/crf_sram_arbiter_pkg.sv
// Shared definitions for the CRF node SRAM arbiter.
// Holds the default widths, the FSM state encoding and the requester-ID width helper.
package crf_sram_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crf_sram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches req upward from ptr, wrapping.
// Ports: req (request vector), ptr (search start) -> grant (one-hot), idx (winner), any.
module crf_sram_arbiter_rr_arbiter
    import crf_sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/crf_sram_arbiter.sv
// Round-robin sequencer sharing one single-port CRF node SRAM between requesters.
// Zero-fills the SRAM after reset, then issues one registered access per cycle.
// Ports: clk/rst; req_valid/write/addr/wdata -> req_ready (one-hot accept);
//        rsp_valid/rsp_id/rsp_rdata (tagged read data); init_done; sram_* pins.
module crf_sram_arbiter
    import crf_sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    localparam int ID_W      = id_w(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         init_done,
    output logic [ADDR_WIDTH-1:0]        sram_addr,
    output logic                         sram_ce,
    output logic                         sram_we,
    output logic [DATA_WIDTH-1:0]        sram_wdata,
    input  logic [DATA_WIDTH-1:0]        sram_rdata
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ID_W-1:0]       rr_ptr, ptr_nxt;
    logic [ID_W-1:0]       win_id, acc_id;
    logic [NUM_REQ-1:0]    grant;
    logic                  any, xfer, acc_rd;
    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    crf_sram_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_id),
        .any   (any)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        xfer      = 1'b0;
        ptr_nxt   = rr_ptr;
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (state == ST_INIT && init_cnt == '1) begin
            state_nxt = ST_RUN;
        end
        // Ready is gated by rst so a mid-run reset cycle never accepts.
        if (state == ST_RUN && !rst) begin
            req_ready = grant;
            xfer      = any;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_write = req_write[i];
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (win_id == ID_W'(NUM_REQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = win_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            rr_ptr     <= '0;
            init_done  <= 1'b0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            acc_id     <= '0;
            acc_rd     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == ST_RUN);
            sram_ce   <= 1'b0;
            sram_we   <= 1'b0;
            acc_rd    <= 1'b0;
            if (state == ST_INIT) begin
                sram_ce    <= 1'b1;
                sram_we    <= 1'b1;
                sram_addr  <= init_cnt;
                sram_wdata <= '0;
                init_cnt   <= init_cnt + 1'b1;
            end else if (xfer) begin
                sram_ce    <= 1'b1;
                sram_we    <= win_write;
                sram_addr  <= win_addr;
                sram_wdata <= win_wdata;
                acc_id     <= win_id;
                acc_rd     <= !win_write;
                rr_ptr     <= ptr_nxt;
            end
            // acc_rd implies sram_ce is high, so outData is driven here.
            rsp_valid <= acc_rd;
            if (acc_rd) begin
                rsp_id    <= acc_id;
                rsp_rdata <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_crf_sram_arbiter.sv
// Self-checking bench for crf_sram_arbiter with an SRAM model and a
// transaction-level reference model of arbitration, memory and responses.
module tb_crf_sram_arbiter;

    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic [3:0]  sram_addr;
    logic        sram_ce;
    logic        sram_we;
    logic [31:0] sram_wdata;
    wire  [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crf_sram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .init_done  (init_done),
        .sram_addr  (sram_addr),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // SRAM: contents scrambled while rst is high so the zero-fill matters.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= $urandom;
        end else if (sram_ce && sram_we) begin
            mem[sram_addr] <= sram_wdata;
        end
    end
    assign sram_rdata = sram_ce ? mem[sram_addr] : 32'bz;

    // Reference model state.
    op_t         q0[$];
    op_t         q1[$];
    int          glog[$];
    logic [31:0] ref_mem [16];
    bit          m_run;
    int          m_icnt;
    int          m_ptr;
    bit          a_v, a_we;
    logic [3:0]  a_addr;
    logic [31:0] a_wdata;
    int          a_id;
    bit          r_v;
    int          r_id;
    logic [31:0] r_data;
    bit          rd_acc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_icnt = 0;
        m_ptr  = 0;
        a_v    = 0;
        a_we   = 0;
        a_id   = 0;
        r_v    = 0;
        r_id   = 0;
        r_data = '0;
    endtask

    task automatic cycle(input bit r);
        logic [1:0] v;
        logic [1:0] eg;
        int         w;
        op_t        o0, o1, op;
        rst = r;
        v   = {q1.size() > 0, q0.size() > 0};
        o0  = v[0] ? q0[0] : '0;
        o1  = v[1] ? q1[0] : '0;
        req_valid = v;
        req_write = {o1.w, o0.w};
        req_addr  = {o1.a, o0.a};
        req_wdata = {o1.d, o0.d};
        #1;
        eg = '0;
        w  = -1;
        if (!r && m_run) begin
            for (int k = 0; k < 2; k++) begin
                if (w < 0 && v[(m_ptr + k) % 2]) w = (m_ptr + k) % 2;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        chk("req_ready", req_ready, eg);
        chk("init_done", init_done, m_run);
        chk("sram_ce", sram_ce, a_v);
        chk("sram_we", sram_we, a_v && a_we);
        if (a_v) begin
            chk("sram_addr", sram_addr, a_addr);
            if (a_we) chk("sram_wdata", sram_wdata, a_wdata);
        end
        chk("rsp_valid", rsp_valid, r_v);
        chk("rsp_id", rsp_id, r_id);
        chk("rsp_rdata", rsp_rdata, r_data);
        @(posedge clk);
        rd_acc = 0;
        if (r) begin
            model_reset();
        end else begin
            r_v = a_v && !a_we;
            if (r_v) begin
                r_id   = a_id;
                r_data = ref_mem[a_addr];
            end
            if (a_v && a_we) ref_mem[a_addr] = a_wdata;
            if (!m_run) begin
                a_v     = 1;
                a_we    = 1;
                a_addr  = 4'(m_icnt);
                a_wdata = '0;
                if (m_icnt == 15) m_run = 1;
                m_icnt++;
            end else if (w >= 0) begin
                op      = (w == 0) ? o0 : o1;
                a_v     = 1;
                a_we    = op.w;
                a_addr  = op.a;
                a_wdata = op.d;
                a_id    = w;
                m_ptr   = (w + 1) % 2;
                rd_acc  = !op.w;
                glog.push_back(w);
                if (w == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end else begin
                a_v  = 0;
                a_we = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input string tag);
        int n = 0;
        while ((!m_run || q0.size() > 0 || q1.size() > 0 || a_v || r_v)
               && n < 200) begin
            cycle(0);
            n++;
        end
        chk(tag, n < 200, 1);
    endtask

    function automatic op_t mk(input bit w, input int a, input logic [31:0] d);
        op_t o;
        o.w = w;
        o.a = 4'(a);
        o.d = d;
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cycle(1);
        cycle(1);
        run_idle("init_done_wait");

        q0.push_back(mk(0, 15, 0));
        run_idle("unread");
        chk("unread_zero", rsp_rdata, 32'h0);

        q0.push_back(mk(1, 3, 32'hDEADBEEF));
        q0.push_back(mk(0, 3, 0));
        run_idle("single_rw");
        chk("single_rw_data", rsp_rdata, 32'hDEADBEEF);

        q0.push_back(mk(1, 5, 32'h55));
        q0.push_back(mk(1, 6, 32'h66));
        run_idle("preload");
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 5, 0));
            q1.push_back(mk(0, 6, 0));
        end
        run_idle("contention");
        chk("contention_grants", glog.size(), 8);
        for (int i = 1; i < glog.size(); i++) begin
            chk("alternate", glog[i] != glog[i-1], 1);
        end

        for (int i = 0; i < 8; i++) q1.push_back(mk(1, i, 32'h100 + i));
        for (int i = 0; i < 8; i++) q1.push_back(mk(0, i, 0));
        run_idle("pipeline");
        chk("pipeline_last", rsp_rdata, 32'h107);

        for (int c = 0; c < 300; c++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) != 0)
                q0.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15),
                                $urandom));
            if (q1.size() < 2 && $urandom_range(0, 2) != 0)
                q1.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15),
                                $urandom));
            cycle(0);
        end
        run_idle("random_drain");

        q0.push_back(mk(0, 2, 0));
        n = 0;
        do begin
            cycle(0);
            n++;
        end while (!rd_acc && n < 10);
        chk("midrst_accept", rd_acc, 1);
        q0.delete();
        q1.delete();
        cycle(1);
        run_idle("reinit");

        q1.push_back(mk(0, 15, 0));
        run_idle("unread_after_reset");
        chk("unread_zero2", rsp_rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
